// File: rtl/shift_register_32_pkg.sv
// Shared constants for the 32-bit shift/rotate/load register and its 4-bit slices.
package shift_register_32_pkg;

  localparam logic [1:0] MODO_SHIFT = 2'b00;
  localparam logic [1:0] MODO_ROT   = 2'b01;
  localparam logic [1:0] MODO_LOAD  = 2'b10;
  localparam logic [1:0] MODO_X     = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int SLICE_W  = 4;
  localparam int N_SLICES = 8;
  localparam int TOTAL_W  = SLICE_W * N_SLICES;

  // Bit that enters the chain end in shift/rotate mode for the given pre-edge contents.
  function automatic logic end_fill(input logic [1:0] modo, input logic dir,
                                    input logic s_in, input logic [TOTAL_W-1:0] q);
    if (modo == MODO_ROT) begin
      return (dir == DIR_RIGHT) ? q[0] : q[TOTAL_W-1];
    end
    return s_in;
  endfunction

endpackage

// File: rtl/shift_register_32_if.sv
// Control and data bundle of shift_register_32; master drives controls, slave returns Q/S_OUT.
interface shift_register_32_if;
  import shift_register_32_pkg::*;

  logic                ENB;
  logic                DIR;
  logic [1:0]          MODO;
  logic                S_IN;
  logic [TOTAL_W-1:0]  D;
  logic [TOTAL_W-1:0]  Q;
  logic [N_SLICES-1:0] S_OUT;

  modport master (output ENB, output DIR, output MODO, output S_IN, output D,
                  input Q, input S_OUT);
  modport slave  (input ENB, input DIR, input MODO, input S_IN, input D,
                  output Q, output S_OUT);

endinterface

// File: rtl/shift_register_4.sv
// One 4-bit slice: shifts its chain input in, loads D, or holds.
// MODO=11 is an independent slice shift when SEGMENTED_SHIFT_EN is defined, hold otherwise.
module shift_register_4
  import shift_register_32_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENB,
  input  logic               DIR,
  input  logic [1:0]         MODO,
  input  logic               S_IN,
  input  logic [SLICE_W-1:0] D,
  output logic [SLICE_W-1:0] Q,
  output logic               S_OUT
);

  logic [SLICE_W-1:0] q_q, q_d;
  logic               s_out_q, s_out_d;
  logic               do_shift;
  logic               do_load;

  always_comb begin
    do_shift = 1'b0;
    do_load  = 1'b0;
    case (MODO)
      MODO_SHIFT, MODO_ROT: do_shift = 1'b1;
      MODO_LOAD:            do_load  = 1'b1;
      MODO_X: begin
`ifdef SEGMENTED_SHIFT_EN
        do_shift = 1'b1;
`else
        do_shift = 1'b0;
`endif
      end
      default: do_shift = 1'b0;
    endcase
  end

  always_comb begin
    q_d     = q_q;
    s_out_d = s_out_q;
    if (ENB) begin
      if (do_load) begin
        q_d     = D;
        s_out_d = 1'b0;
      end else if (do_shift) begin
        if (DIR == DIR_RIGHT) begin
          q_d     = {S_IN, q_q[SLICE_W-1:1]};
          s_out_d = q_q[0];
        end else begin
          q_d     = {q_q[SLICE_W-2:0], S_IN};
          s_out_d = q_q[SLICE_W-1];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q     <= '0;
      s_out_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      s_out_q <= s_out_d;
    end
  end

  assign Q     = q_q;
  assign S_OUT = s_out_q;

endmodule

// File: rtl/shift_register_32.sv
// 32-bit bidirectional shift/rotate/load register built from eight chained 4-bit slices.
// Optional SEGMENTED_SHIFT_EN turns MODO=11 into a per-slice shift with the chain cut.
module shift_register_32
  import shift_register_32_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  shift_register_32_if.slave bus
);

  logic [TOTAL_W-1:0]  q_all;
  logic [N_SLICES-1:0] s_out_all;
  logic [N_SLICES-1:0] left_in;
  logic [N_SLICES-1:0] right_in;
  logic [N_SLICES-1:0] chain_in;
  logic                end_in;
  logic                seg_mode;

  assign end_in = end_fill(bus.MODO, bus.DIR, bus.S_IN, q_all);

`ifdef SEGMENTED_SHIFT_EN
  assign seg_mode = (bus.MODO == MODO_X);
`else
  assign seg_mode = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_SLICES; gi++) begin : g_slice
      // Left chain: fed by the MSB of the slice below; slice 0 takes the end fill.
      if (gi == 0) begin : g_left_end
        assign left_in[gi] = end_in;
      end else begin : g_left_mid
        assign left_in[gi] = q_all[SLICE_W*gi-1];
      end

      // Right chain: fed by the LSB of the slice above; the top slice takes the end fill.
      if (gi == N_SLICES-1) begin : g_right_end
        assign right_in[gi] = end_in;
      end else begin : g_right_mid
        assign right_in[gi] = q_all[SLICE_W*(gi+1)];
      end

      assign chain_in[gi] = seg_mode ? bus.S_IN
                          : ((bus.DIR == DIR_RIGHT) ? right_in[gi] : left_in[gi]);

      shift_register_4 u_slice (
        .CLK   (CLK),
        .RESET (RESET),
        .ENB   (bus.ENB),
        .DIR   (bus.DIR),
        .MODO  (bus.MODO),
        .S_IN  (chain_in[gi]),
        .D     (bus.D[SLICE_W*gi +: SLICE_W]),
        .Q     (q_all[SLICE_W*gi +: SLICE_W]),
        .S_OUT (s_out_all[gi])
      );
    end
  endgenerate

  assign bus.Q     = q_all;
  assign bus.S_OUT = s_out_all;

endmodule

// File: tb/tb_shift_register_32.sv
// Scoreboard bench for shift_register_32: directed cases plus random stimulus checked
// against a word-level reference model.
module tb_shift_register_32;
  import shift_register_32_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_register_32_if bus();

  shift_register_32 dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] q;
    logic [7:0]  s;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mq;
  logic [7:0]  ms;
  int          n_cmp     = 0;
  int          n_err     = 0;
  bit          stim_done = 1'b0;

  // Reference model: whole-word next state derived from the operation rules.
  task automatic model_next(input bit r, input bit e, input bit dr, input logic [1:0] m,
                            input bit si, input logic [31:0] d);
    logic [31:0] nq;
    logic [7:0]  ns;
    logic        fill;
    nq = mq;
    ns = ms;
    if (r) begin
      nq = '0;
      ns = '0;
    end else if (e) begin
      if (m == 2'b00 || m == 2'b01) begin
        fill = (m == 2'b00) ? si : (dr ? mq[0] : mq[31]);
        nq = dr ? {fill, mq[31:1]} : {mq[30:0], fill};
        for (int i = 0; i < 8; i++) ns[i] = dr ? mq[4*i] : mq[4*i+3];
      end else if (m == 2'b10) begin
        nq = d;
        ns = '0;
      end else begin
`ifdef SEGMENTED_SHIFT_EN
        for (int i = 0; i < 8; i++) begin
          logic [3:0] nib;
          nib = mq[4*i +: 4];
          ns[i] = dr ? nib[0] : nib[3];
          nq[4*i +: 4] = dr ? {si, nib[3:1]} : {nib[2:0], si};
        end
`endif
      end
    end
    mq = nq;
    ms = ns;
  endtask

  // Drive one cycle of stimulus; expected is the model unless a constant is supplied.
  task automatic step(input bit r, input bit e, input bit dr, input logic [1:0] m,
                      input bit si, input logic [31:0] d, input string nm,
                      input bit use_c = 1'b0, input logic [31:0] cq = '0,
                      input logic [7:0] cs = '0);
    exp_t x;
    @(negedge clk);
    rst      = r;
    bus.ENB  = e;
    bus.DIR  = dr;
    bus.MODO = m;
    bus.S_IN = si;
    bus.D    = d;
    model_next(r, e, dr, m, si, d);
    x.q    = use_c ? cq : mq;
    x.s    = use_c ? cs : ms;
    x.name = nm;
    sb.push_back(x);
  endtask

  initial begin
    rst = 1'b1; bus.ENB = 1'b0; bus.DIR = 1'b0; bus.MODO = 2'b00; bus.S_IN = 1'b0; bus.D = '0;
    mq = '0; ms = '0;

    step(1, 1, 0, MODO_LOAD, 0, 32'hFFFF_FFFF, "reset_a", 1, 32'h0, 8'h00);
    step(1, 1, 0, MODO_LOAD, 0, 32'hFFFF_FFFF, "reset_b", 1, 32'h0, 8'h00);
    step(0, 1, 0, MODO_LOAD, 0, 32'hFFFF_FFFF, "load_ff", 1, 32'hFFFF_FFFF, 8'h00);

    step(0, 1, 0, MODO_LOAD, 0, 32'h8000_0001, "load_81", 1, 32'h8000_0001, 8'h00);
    step(0, 1, DIR_LEFT, MODO_SHIFT, 1, 32'h0, "shl_sin1", 1, 32'h0000_0003, 8'h80);

    step(0, 1, 0, MODO_LOAD, 0, 32'h0000_0001, "load_01", 1, 32'h0000_0001, 8'h00);
    step(0, 1, DIR_RIGHT, MODO_ROT, 1, 32'h0, "rotr_1", 1, 32'h8000_0000, 8'h01);
    for (int i = 0; i < 30; i++) step(0, 1, DIR_RIGHT, MODO_ROT, 0, $urandom, "rotr_run");
    step(0, 1, DIR_RIGHT, MODO_ROT, 1, 32'h0, "rotr_wrap", 1, 32'h0000_0001, 8'h00);

    step(0, 1, 0, MODO_LOAD, 0, 32'hA5A5_A5A5, "load_a5", 1, 32'hA5A5_A5A5, 8'h00);
    for (int i = 0; i < 5; i++)
      step(0, 0, DIR_LEFT, MODO_SHIFT, 1, $urandom, "enb_freeze", 1, 32'hA5A5_A5A5, 8'h00);
    step(0, 1, DIR_LEFT, MODO_SHIFT, 0, 32'h0, "shl_after_freeze", 1, 32'h4B4B_4B4A, 8'hAA);

    step(0, 1, 0, MODO_LOAD, 0, 32'h1234_5678, "load_mid");
    for (int i = 0; i < 3; i++) step(0, 1, DIR_LEFT, MODO_ROT, 0, 32'h0, "rotl_run");
    step(1, 1, DIR_LEFT, MODO_ROT, 0, 32'h0, "reset_mid", 1, 32'h0, 8'h00);
    step(0, 1, DIR_LEFT, MODO_ROT, 1, 32'h0, "rot_after_reset", 1, 32'h0, 8'h00);

    step(0, 1, 0, MODO_LOAD, 0, 32'h8888_8888, "load_88", 1, 32'h8888_8888, 8'h00);
`ifdef SEGMENTED_SHIFT_EN
    step(0, 1, DIR_LEFT, MODO_X, 1, 32'h0, "mode11_seg", 1, 32'h1111_1111, 8'hFF);
`else
    step(0, 1, DIR_LEFT, MODO_X, 1, 32'h0, "mode11_hold", 1, 32'h8888_8888, 8'h00);
`endif

    step(0, 1, DIR_LEFT, MODO_SHIFT, 0, 32'h0, "left_shift_zero");
    for (int i = 0; i < 31; i++) step(0, 1, DIR_LEFT, MODO_SHIFT, 0, 32'h0, "shift_zero_run");
    step(0, 1, DIR_LEFT, MODO_SHIFT, 0, 32'h0, "shift_zero_end", 1, 32'h0, 8'h00);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), $urandom_range(0, 1),
           2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom, "random");
    end
    stim_done = 1'b1;
  end

  // Monitor: one expected entry per clock edge following each stimulus cycle.
  initial begin
    exp_t x;
    int   idle;
    idle = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_cmp++;
        idle = 0;
        if (bus.Q !== x.q || bus.S_OUT !== x.s) begin
          n_err++;
          $display("FAIL %s: Q=%h S_OUT=%h expected Q=%h S_OUT=%h",
                   x.name, bus.Q, bus.S_OUT, x.q, x.s);
        end else begin
          $display("ok   %s: Q=%h S_OUT=%h", x.name, bus.Q, bus.S_OUT);
        end
      end else if (stim_done) begin
        break;
      end else begin
        idle++;
        if (idle > 2000) begin
          n_cmp++;
          n_err++;
          $display("FAIL timeout: no stimulus after %0d cycles, expected progress", idle);
          break;
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_register_32.md
# shift_register_32

32-bit bidirectional shift/rotate/load register built from eight chained 4-bit slices. It is the device under test that produces the Q (32-bit) and S_OUT (8-bit) vectors consumed by the comparison checker. Two instances, a behavioural one and a structural one, run the same stimulus in each test so the checker can compare their outputs cycle by cycle.

## Interface

Parameters:
- none. Width is fixed at 32 bits, made of 8 slices of 4 bits.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- ENB  input  1  enable. When 0, Q and S_OUT hold.
- DIR  input  1  0 = shift/rotate toward MSB (left); 1 = toward LSB (right).
- MODO  input  2  00 shift, 01 rotate, 10 parallel load, 11 hold (or segmented shift; see Configuration).
- S_IN  input  1  serial input bit for shift mode.
- D  input  32  parallel load data.
- Q  output  32  register contents.
- S_OUT  output  8  S_OUT[i] is the registered bit that left slice i on the last shift or rotate.

## Operation

- Slice i owns Q[4i+3:4i]. Slices are chained:
  - Left: slice i's MSB feeds slice i+1's LSB.
  - Right: slice i's LSB feeds slice i-1's MSB.
- Shift (00):
  - DIR=0: Q <= {Q[30:0], S_IN}.
  - DIR=1: Q <= {S_IN, Q[31:1]}.
  - S_OUT[i] <= Q[4i+3] (DIR=0) or Q[4i] (DIR=1), taken from the pre-edge value.
- Rotate (01):
  - DIR=0: Q <= {Q[30:0], Q[31]}.
  - DIR=1: Q <= {Q[0], Q[31:1]}.
  - S_OUT is updated with the same rule as shift.
- Load (10): Q <= D; S_OUT <= 8'h00.
- Mode 11 without the macro: Q and S_OUT hold.
- Priority: RESET > ENB=0 > MODO.
- RESET=1 at a rising edge sets Q=0 and S_OUT=0, regardless of ENB, MODO or D.
- S_IN is ignored in rotate and load.

## Timing

- All updates take effect one cycle after the sampled edge. There is no combinational path from inputs to outputs.
- Reset value: Q=32'h0000_0000, S_OUT=8'h00. The first valid operation happens on the first edge with RESET=0.
- Reset asserted mid-sequence clears both outputs on that edge. Operation resumes on the next edge with RESET=0, starting from zero.
- ENB deasserted for N cycles: outputs are frozen for exactly N edges, and no shift is lost or duplicated.
- DIR or MODO changing between consecutive edges is legal. Each edge uses only the values sampled at that edge.
- Wrap-around: 32 consecutive rotates in the same direction return Q to its starting value.
- 32 consecutive shifts with S_IN=0 give Q=0.

## Configuration

- SEGMENTED_SHIFT_EN:
  - Defined: MODO=11 is segmented shift. Each slice shifts independently in direction DIR, with S_IN entering every slice (the slice chaining is cut). S_OUT[i] is the bit leaving slice i.
  - Undefined: MODO=11 is hold.
  - Both instances compared by the checker must be built with the same setting.

## Structure

- Shared package/header holds:
  - mode constants MODO_SHIFT=2'b00, MODO_ROT=2'b01, MODO_LOAD=2'b10, MODO_X=2'b11;
  - DIR_LEFT=1'b0 and DIR_RIGHT=1'b1;
  - SLICE_W=4 and N_SLICES=8.
- Sub-module shift_register_4 is one slice, with these ports:
  - CLK, RESET, ENB, DIR, MODO, S_IN (the chain input), D[3:0];
  - Q[3:0] and S_OUT.
- The top module instantiates 8 slices and routes:
  - each slice's chain input from its neighbour's edge bit;
  - the end-slice inputs from S_IN (shift) or from Q[31]/Q[0] (rotate).

## Test plan

- Reset: RESET=1 for 2 cycles with D=32'hFFFF_FFFF and MODO=10 -> Q=0, S_OUT=0. Release RESET, load the same D -> Q=32'hFFFF_FFFF one cycle later, S_OUT=0.
- Left shift: load 32'h8000_0001, then 1 shift with DIR=0, S_IN=1 -> Q=32'h0000_0003, S_OUT=8'h80.
- Right rotate wrap: load 32'h0000_0001, then 1 rotate with DIR=1 -> Q=32'h8000_0000, S_OUT=8'h01. After 31 more rotates, Q=32'h0000_0001.
- Enable freeze: load 32'hA5A5_A5A5, hold ENB=0 for 5 cycles while in shift mode -> Q and S_OUT unchanged. Set ENB=1 for 1 left shift with S_IN=0 -> Q=32'h4B4B_4B4A.
- Reset mid-operation: during a run of rotates, RESET=1 for 1 cycle -> Q=0, S_OUT=0 on that edge. The next rotate leaves Q=0.
- Mode 11:
  - SEGMENTED_SHIFT_EN defined: load 32'h8888_8888, then left segmented shift with S_IN=1 -> Q=32'h1111_1111, S_OUT=8'hFF.
  - SEGMENTED_SHIFT_EN undefined: the same stimulus leaves Q=32'h8888_8888 and S_OUT=8'h00.
